legv8_control_sequencer: RTL

Multi-cycle control sequencer for the 64-bit LegV8 datapath. It decodes the instruction word into the datapath control-word fields (DA/SA/SB/FS/PS/enable/strobes/k) and sequences instructions that need more than one cycle: CBZ/CBNZ (test then branch) and LDUR/STUR (data-memory handshake). It sits between instruction memory and the register file/ALU/PC/data-memory datapath, and is the single source of every datapath strobe.

---
 rtl/legv8_control_sequencer_if.sv | 33 +++
 rtl/legv8_control_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/legv8_control_sequencer_if.sv
// Control bundle between the LegV8 sequencer and the datapath it drives.
// The sequencer uses the slave view; the datapath (or a bench) uses master.
interface legv8_control_sequencer_if;
  logic [31:0] instruction;
  logic [3:0]  status;
  logic        alu_zero;
  logic        mem_ready;
  logic [4:0]  DA;
  logic [4:0]  SA;
  logic [4:0]  SB;
  logic [4:0]  FS;
  logic [1:0]  PS;
  logic [1:0]  enable;
  logic        regWrite;
  logic        memWrite;
  logic        status_load;
  logic        mem_req;
  logic        B_sel;
  logic [63:0] k;
  logic        state;

  modport master (
    output instruction, status, alu_zero, mem_ready,
    input  DA, SA, SB, FS, PS, enable, regWrite, memWrite,
           status_load, mem_req, B_sel, k, state
  );

  modport slave (
    input  instruction, status, alu_zero, mem_ready,
    output DA, SA, SB, FS, PS, enable, regWrite, memWrite,
           status_load, mem_req, B_sel, k, state
  );
endinterface

// File: rtl/legv8_control_sequencer.sv
// LegV8 control sequencer: decodes the instruction into a control word and
// stretches CBZ/CBNZ and LDUR/STUR over a second state.
module legv8_control_sequencer (
  input  logic                          clock,
  input  logic                          reset,
  legv8_control_sequencer_if.slave      bus
);

  typedef enum logic [1:0] {
    S_EXEC   = 2'd0,
    S_SECOND = 2'd1,
    S_HALT   = 2'd2
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_ADDS, OP_SUBS, OP_ADDI, OP_SUBI,
    OP_B, OP_BL, OP_BCOND, OP_CBZ, OP_CBNZ, OP_LDUR, OP_STUR, OP_BAD
  } op_e;

  localparam logic [4:0] FS_AND    = 5'd0;
  localparam logic [4:0] FS_ORR    = 5'd1;
  localparam logic [4:0] FS_ADD    = 5'd2;
  localparam logic [4:0] FS_SUB    = 5'd3;
  localparam logic [4:0] FS_PASS_B = 5'd4;

  localparam logic [1:0] PS_HOLD   = 2'b00;
  localparam logic [1:0] PS_INC    = 2'b01;
  localparam logic [1:0] PS_BRANCH = 2'b10;

  localparam logic [1:0] EN_ALU  = 2'b00;
  localparam logic [1:0] EN_MEM  = 2'b01;
  localparam logic [1:0] EN_PC4  = 2'b10;
  localparam logic [1:0] EN_NONE = 2'b11;

  state_e      state_q, state_d;
  op_e         op;
  logic [31:0] instr;
  logic [4:0]  rd, rn, rm;
  logic [63:0] imm_br26, imm_br19, imm_dt, imm_alu;
  logic        flag_v, flag_c, flag_n, flag_z;
  logic        cond_true;
  logic        cb_taken;

  logic [4:0]  da, sa, sb, fs;
  logic [1:0]  ps, en;
  logic        reg_write, mem_write, status_load, mem_req, b_sel;
  logic [63:0] k;

  assign instr = bus.instruction;
  assign rd    = instr[4:0];
  assign rn    = instr[9:5];
  assign rm    = instr[20:16];

  assign imm_br26 = {{36{instr[25]}}, instr[25:0], 2'b00};
  assign imm_br19 = {{43{instr[23]}}, instr[23:5], 2'b00};
  assign imm_dt   = {{55{instr[20]}}, instr[20:12]};
  assign imm_alu  = {52'd0, instr[21:10]};

  assign flag_v = bus.status[3];
  assign flag_c = bus.status[2];
  assign flag_n = bus.status[1];
  assign flag_z = bus.status[0];

  always_comb begin
    casez (instr[31:21])
      11'b10001011000: op = OP_ADD;
      11'b11001011000: op = OP_SUB;
      11'b10001010000: op = OP_AND;
      11'b10101010000: op = OP_ORR;
      11'b10101011000: op = OP_ADDS;
      11'b11101011000: op = OP_SUBS;
      11'b1001000100?: op = OP_ADDI;
      11'b1101000100?: op = OP_SUBI;
      11'b000101?????: op = OP_B;
      11'b100101?????: op = OP_BL;
      11'b01010100???: op = instr[4] ? OP_BAD : OP_BCOND;
      11'b10110100???: op = OP_CBZ;
      11'b10110101???: op = OP_CBNZ;
      11'b11111000010: op = OP_LDUR;
      11'b11111000000: op = OP_STUR;
      default:         op = OP_BAD;
    endcase
  end

  always_comb begin
    case (instr[3:0])
      4'b0000: cond_true = flag_z;
      4'b0001: cond_true = !flag_z;
      4'b0010: cond_true = flag_c;
      4'b0011: cond_true = !flag_c;
      4'b0100: cond_true = flag_n;
      4'b0101: cond_true = !flag_n;
      4'b0110: cond_true = flag_v;
      4'b0111: cond_true = !flag_v;
      4'b1000: cond_true = flag_c && !flag_z;
      4'b1001: cond_true = !flag_c || flag_z;
      4'b1010: cond_true = (flag_n == flag_v);
      4'b1011: cond_true = (flag_n != flag_v);
      4'b1100: cond_true = !flag_z && (flag_n == flag_v);
      4'b1101: cond_true = flag_z || (flag_n != flag_v);
      default: cond_true = 1'b1;
    endcase
  end

  // alu_zero is live, so it is only meaningful once Rt is on the ALU (SECOND)
  assign cb_taken = (op == OP_CBZ) ? bus.alu_zero : !bus.alu_zero;

  // Everything is forced to the idle word while reset is held low
  always_comb begin
    state_d     = state_q;
    da          = rd;
    sa          = rn;
    sb          = rm;
    fs          = FS_AND;
    ps          = PS_HOLD;
    en          = EN_NONE;
    reg_write   = 1'b0;
    mem_write   = 1'b0;
    status_load = 1'b0;
    mem_req     = 1'b0;
    b_sel       = 1'b0;
    k           = 64'd0;
    if (reset) begin
      case (state_q)
        S_EXEC: begin
          case (op)
            OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_ADDS, OP_SUBS, OP_ADDI, OP_SUBI: begin
              en          = EN_ALU;
              reg_write   = 1'b1;
              ps          = PS_INC;
              b_sel       = (op == OP_ADDI) || (op == OP_SUBI);
              status_load = (op == OP_ADDS) || (op == OP_SUBS);
              if (b_sel) k = imm_alu;
              case (op)
                OP_AND:                  fs = FS_AND;
                OP_ORR:                  fs = FS_ORR;
                OP_SUB, OP_SUBS, OP_SUBI: fs = FS_SUB;
                default:                 fs = FS_ADD;
              endcase
            end
            OP_B: begin
              ps = PS_BRANCH;
              k  = imm_br26;
            end
            OP_BL: begin
              da        = 5'd30;
              en        = EN_PC4;
              reg_write = 1'b1;
              ps        = PS_BRANCH;
              k         = imm_br26;
            end
            OP_BCOND: begin
              k  = imm_br19;
              ps = cond_true ? PS_BRANCH : PS_INC;
            end
            OP_CBZ, OP_CBNZ: begin
              sb      = rd;
              fs      = FS_PASS_B;
              k       = imm_br19;
              state_d = S_SECOND;
            end
            OP_LDUR, OP_STUR: begin
              sa      = rn;
              b_sel   = 1'b1;
              fs      = FS_ADD;
              k       = imm_dt;
              mem_req = 1'b1;
              if (op == OP_STUR) begin
                sb        = rd;
                mem_write = 1'b1;
              end
              state_d = S_SECOND;
            end
            default: state_d = S_HALT;
          endcase
        end
        S_SECOND: begin
          case (op)
            OP_CBZ, OP_CBNZ: begin
              sb      = rd;
              fs      = FS_PASS_B;
              k       = imm_br19;
              ps      = cb_taken ? PS_BRANCH : PS_INC;
              state_d = S_EXEC;
            end
            OP_LDUR, OP_STUR: begin
              sa      = rn;
              b_sel   = 1'b1;
              fs      = FS_ADD;
              k       = imm_dt;
              mem_req = 1'b1;
              if (op == OP_STUR) begin
                sb        = rd;
                mem_write = 1'b1;
              end
              if (bus.mem_ready) begin
                ps      = PS_INC;
                state_d = S_EXEC;
                if (op == OP_LDUR) begin
                  da        = rd;
                  en        = EN_MEM;
                  reg_write = 1'b1;
                end
              end
            end
            default: state_d = S_EXEC;
          endcase
        end
        default: state_d = S_HALT;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_EXEC;
    else        state_q <= state_d;
  end

  assign bus.DA          = da;
  assign bus.SA          = sa;
  assign bus.SB          = sb;
  assign bus.FS          = fs;
  assign bus.PS          = ps;
  assign bus.enable      = en;
  assign bus.regWrite    = reg_write;
  assign bus.memWrite    = mem_write;
  assign bus.status_load = status_load;
  assign bus.mem_req     = mem_req;
  assign bus.B_sel       = b_sel;
  assign bus.k           = k;
  assign bus.state       = (state_q == S_SECOND);

endmodule
